mem_stage_unit: RTL
===================

Name: mem_stage_unit

Overview:
Memory-stage consumer of the EX/MEM pipeline latch outputs (the `*_m` signals). It performs the data-memory access through a req/ack handshake and stalls upstream while an access is outstanding. It selects the writeback value (PC+4, load data, or ALU result) and registers the MEM/WB latch outputs (the `*_w` signals) for the writeback stage.

Parameters:
DBITS, 32, data/address width
REGNOBITS, 4, destination register index width
TIMEOUT, 16, max cycles to wait for dmem_ack (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_m  in  1  EX/MEM slot holds a real instruction (0 = bubble)
memtoReg_m  in  1  load: writeback takes memory data
memWrite_m  in  1  store
jal_m  in  1  writeback takes incrementedPC_m
regWrite_m  in  1  instruction writes register file
wrReg_m  in  REGNOBITS  destination register
incrementedPC_m  in  DBITS  PC+4
aluOut_m  in  DBITS  ALU result / memory address
sr2Out_m  in  DBITS  store data
dmem_req  out  1  memory request, registered
dmem_we  out  1  request is a write, registered
dmem_addr  out  DBITS  byte address, registered
dmem_wdata  out  DBITS  write data, registered
dmem_rdata  in  DBITS  read data, valid when dmem_ack=1
dmem_ack  in  1  access complete (one-cycle pulse)
stall  out  1  hold EX/MEM contents and upstream stages (combinational)
valid_w  out  1  MEM/WB slot valid
regWrite_w  out  1  register-file write enable (already gated by valid_w)
wrReg_w  out  REGNOBITS  destination register
wbData_w  out  DBITS  writeback value
err  out  1  sticky memory-timeout flag (0 when macro is off)

Behaviour:
- Reset: state=IDLE. All registered outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, valid_w, regWrite_w, wrReg_w, wbData_w, err. stall=0 while reset is high.
- Memory op: memop = valid_m & (memtoReg_m | memWrite_m).
- FSM states: IDLE, ACCESS.
- IDLE, valid_m & !memop:
  - Next edge: valid_w=1, regWrite_w=regWrite_m, wrReg_w=wrReg_m.
  - wbData_w = jal_m ? incrementedPC_m : aluOut_m.
  - stall=0. Latency 1 cycle.
- IDLE, !valid_m: next edge valid_w=0, regWrite_w=0; the other MEM/WB fields hold.
- IDLE, memop:
  - stall=1 this cycle.
  - Next edge: dmem_req=1, dmem_we=memWrite_m, dmem_addr=aluOut_m, dmem_wdata=sr2Out_m; go to ACCESS; valid_w=0, regWrite_w=0 (bubble).
  - If both memtoReg_m and memWrite_m are set, the store takes priority (dmem_we=1) and regWrite_w is forced to 0.
- ACCESS, dmem_ack=0:
  - stall=1; request signals held; valid_w=0, regWrite_w=0.
- ACCESS, dmem_ack=1:
  - stall=0, so upstream advances at this edge.
  - Next edge: dmem_req=0, dmem_we=0, state=IDLE, valid_w=1, wrReg_w=wrReg_m.
  - Load: wbData_w=dmem_rdata, regWrite_w=regWrite_m.
  - Store: regWrite_w=0; wbData_w=aluOut_m.
  - The following instruction is examined in IDLE on the next cycle, so there are no back-to-back requests without an IDLE cycle.
- Memory-op latency: 1 cycle + wait cycles + 1 cycle. With ack in the first ACCESS cycle, valid_w rises 2 edges after the op was presented.
- dmem_ack while in IDLE is ignored.
- Reset mid-ACCESS: at the next edge dmem_req=0 and state=IDLE; the pending op is dropped; a later stray ack is ignored.
- EX/MEM inputs are guaranteed stable while stall=1; the block does not re-latch them.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT with no ack: stall=0 that cycle. Next edge: err=1 (sticky until reset), dmem_req=0, state=IDLE, valid_w=1, regWrite_w=0.
  - Ack on the TIMEOUT cycle counts as a normal completion.
- Undefined: no counter; ACCESS waits indefinitely; err tied to 0.

Test Plan:
- ALU op (valid_m=1, regWrite_m=1, wrReg_m=3, aluOut_m=0x0000_0010) -> next edge valid_w=1, regWrite_w=1, wrReg_w=3, wbData_w=0x10, stall never asserts.
- jal (jal_m=1, incrementedPC_m=0x104, aluOut_m=0x55) -> wbData_w=0x104.
- Load (memtoReg_m=1, aluOut_m=0x200, wrReg_m=5), ack with rdata=0xDEADBEEF on the 3rd ACCESS cycle:
  - dmem_req high for 3 cycles with dmem_addr=0x200, dmem_we=0; stall high 3 cycles.
  - Then valid_w=1, wrReg_w=5, wbData_w=0xDEADBEEF.
- Store (memWrite_m=1, aluOut_m=0x300, sr2Out_m=0x1234), immediate ack -> dmem_we=1, dmem_wdata=0x1234, then valid_w=1 with regWrite_w=0.
- Reset asserted in the 2nd ACCESS cycle, then ack pulsed after reset -> dmem_req=0 after the reset edge, valid_w stays 0, no writeback.
- MEM_TIMEOUT_EN with TIMEOUT=4, load never acked -> after 4 ACCESS cycles err=1, dmem_req=0, valid_w=1 with regWrite_w=0, stall released.

Source files
------------

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - memory stage: data-memory req/ack access, stall control, MEM/WB latch (optional MEM_TIMEOUT_EN)
module mem_stage_unit #(
    parameter int DBITS     = 32,
    parameter int REGNOBITS = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_m,
    input  logic                 memtoReg_m,
    input  logic                 memWrite_m,
    input  logic                 jal_m,
    input  logic                 regWrite_m,
    input  logic [REGNOBITS-1:0] wrReg_m,
    input  logic [DBITS-1:0]     incrementedPC_m,
    input  logic [DBITS-1:0]     aluOut_m,
    input  logic [DBITS-1:0]     sr2Out_m,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DBITS-1:0]     dmem_addr,
    output logic [DBITS-1:0]     dmem_wdata,
    input  logic [DBITS-1:0]     dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 stall,
    output logic                 valid_w,
    output logic                 regWrite_w,
    output logic [REGNOBITS-1:0] wrReg_w,
    output logic [DBITS-1:0]     wbData_w,
    output logic                 err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state, stateNext;
    logic   memop;
    logic   timeoutHit;

    assign memop = valid_m & (memtoReg_m | memWrite_m);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] toCnt;

    // The TIMEOUT-th unacknowledged ACCESS cycle abandons the access
    assign timeoutHit = (state == ACCESS) && !dmem_ack && (toCnt == CW'(TIMEOUT - 1));

    // Wait-cycle counter, cleared while idle so it starts at zero on entry to ACCESS
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            toCnt <= '0;
        end else if (!dmem_ack) begin
            toCnt <= toCnt + 1'b1;
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (timeoutHit) begin
            err <= 1'b1;
        end
    end
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = |TIMEOUT;
    assign timeoutHit       = 1'b0;
    assign err              = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and upstream stall; stall drops in the completing cycle so upstream advances
    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    stall     = 1'b1;
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_ack || timeoutHit) begin
                    stateNext = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (reset) begin
            stall     = 1'b0;
            stateNext = IDLE;
        end
    end

    // Memory request registers and MEM/WB latch
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            valid_w    <= 1'b0;
            regWrite_w <= 1'b0;
            wrReg_w    <= '0;
            wbData_w   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        // Store wins when both flags are set; the slot becomes a bubble while waiting
                        dmem_req   <= 1'b1;
                        dmem_we    <= memWrite_m;
                        dmem_addr  <= aluOut_m;
                        dmem_wdata <= sr2Out_m;
                        valid_w    <= 1'b0;
                        regWrite_w <= 1'b0;
                    end else if (valid_m) begin
                        valid_w    <= 1'b1;
                        regWrite_w <= regWrite_m;
                        wrReg_w    <= wrReg_m;
                        wbData_w   <= jal_m ? incrementedPC_m : aluOut_m;
                    end else begin
                        valid_w    <= 1'b0;
                        regWrite_w <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        valid_w  <= 1'b1;
                        wrReg_w  <= wrReg_m;
                        if (dmem_we) begin
                            regWrite_w <= 1'b0;
                            wbData_w   <= aluOut_m;
                        end else begin
                            regWrite_w <= regWrite_m;
                            wbData_w   <= dmem_rdata;
                        end
                    end else if (timeoutHit) begin
                        // Abandoned access retires as a valid slot that writes nothing
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        valid_w    <= 1'b1;
                        regWrite_w <= 1'b0;
                    end else begin
                        valid_w    <= 1'b0;
                        regWrite_w <= 1'b0;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
